// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared constants and types for the two-stage pipeline sequencer.
// Opcodes, sequencer states and the source-operand match helper.
package pipeline_hazard_ctrl_pkg;

    localparam logic [3:0] OP1_BCOND = 4'b0110;
    localparam logic [3:0] OP1_JAL   = 4'b1011;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LD_STALL = 2'd1,
        ST_FLUSH    = 2'd2,
        ST_MEM_WAIT = 2'd3
    } state_t;

    function automatic logic src_match(
        input logic       uses,
        input logic [3:0] rs,
        input logic [3:0] rd
    );
        return uses && (rs == rd);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
// Holds at all-ones once reached; synchronous clear has priority over inc.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: load-use stalls, redirect squash and memory waits.
// Outputs are combinational from the current state and the D/M stage inputs.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_BITS     = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          dOpcode,
    input  logic [3:0]          dRs1,
    input  logic [3:0]          dRs2,
    input  logic                dUsesRs1,
    input  logic                dUsesRs2,
    input  logic                dBrTaken,
    input  logic                mIsLoad,
    input  logic                mRegWrEn,
    input  logic [3:0]          mRd,
    input  logic                memBusy,
    output logic                pcWrtEn,
    output logic                pipeWrtEn,
    output logic                pipeBubble,
    output logic                dSquash,
    output logic                redirect,
    output logic [CNT_BITS-1:0] stallCnt,
    output logic [CNT_BITS-1:0] flushCnt
);

    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES);

    state_t     state, state_nxt;
    state_t     ret_state, ret_state_nxt;
    state_t     eff;
    logic [1:0] fcnt, fcnt_nxt;
    logic       hazard, redir;
    logic       stall_inc, flush_inc;

    // A finished memory wait behaves exactly like the interrupted state.
    assign eff = (state == ST_MEM_WAIT) ? ret_state : state;

    assign hazard = mIsLoad && mRegWrEn &&
                    (src_match(dUsesRs1, dRs1, mRd) ||
                     src_match(dUsesRs2, dRs2, mRd));

    assign redir = ((dOpcode == OP1_BCOND) && dBrTaken) ||
                   (dOpcode == OP1_JAL);

    always_comb begin
        state_nxt     = state;
        ret_state_nxt = ret_state;
        fcnt_nxt      = fcnt;
        pcWrtEn       = 1'b1;
        pipeWrtEn     = 1'b1;
        pipeBubble    = 1'b0;
        dSquash       = 1'b0;
        redirect      = 1'b0;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;
        if (!reset) begin
            pcWrtEn    = 1'b0;
            pipeBubble = 1'b1;
            dSquash    = 1'b1;
        end else if (memBusy) begin
            pcWrtEn       = 1'b0;
            pipeWrtEn     = 1'b0;
            dSquash       = (eff == ST_FLUSH);
            stall_inc     = 1'b1;
            state_nxt     = ST_MEM_WAIT;
            ret_state_nxt = eff;
        end else if (eff == ST_FLUSH) begin
            dSquash    = 1'b1;
            pipeBubble = 1'b1;
            flush_inc  = 1'b1;
            fcnt_nxt   = fcnt - 2'd1;
            state_nxt  = (fcnt <= 2'd1) ? ST_RUN : ST_FLUSH;
        end else if (hazard && (eff == ST_RUN)) begin
            // The load retires during the bubble, so LD_STALL ignores it.
            pcWrtEn    = 1'b0;
            pipeBubble = 1'b1;
            stall_inc  = 1'b1;
            state_nxt  = ST_LD_STALL;
        end else if (redir) begin
            redirect  = 1'b1;
            fcnt_nxt  = FLUSH_INIT;
            state_nxt = ST_FLUSH;
        end else begin
            state_nxt = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_RUN;
            ret_state <= ST_RUN;
            fcnt      <= '0;
        end else begin
            state     <= state_nxt;
            ret_state <= ret_state_nxt;
            fcnt      <= fcnt_nxt;
        end
    end

    sat_counter #(.W(CNT_BITS)) u_stall_cnt (
        .clk   (clk),
        .rst_n (reset),
        .clr   (1'b0),
        .inc   (stall_inc),
        .cnt   (stallCnt)
    );

    sat_counter #(.W(CNT_BITS)) u_flush_cnt (
        .clk   (clk),
        .rst_n (reset),
        .clr   (1'b0),
        .inc   (flush_inc),
        .cnt   (flushCnt)
    );

endmodule
